// File: rtl/bmp_stream_writer.sv
// bmp_stream_writer: turns a frame of multi-pixel RGB888 beats into a complete
// 24-bit Windows BMP byte stream (54-byte header, rows padded to 4 bytes).
module bmp_stream_writer #(
    parameter int WIDTH        = 768,
    parameter int HEIGHT       = 512,
    parameter int PIX_PER_BEAT = 2,
    parameter int TOP_DOWN     = 0,
    parameter int HDR_BYTES    = 54
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [24*PIX_PER_BEAT-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       busy,
    output logic                       Write_Done
);
    localparam int ROW_RAW       = 3 * WIDTH;
    localparam int PAD_BYTES     = (4 - ROW_RAW % 4) % 4;
    localparam int ROW_BYTES     = ROW_RAW + PAD_BYTES;
    localparam int IMG_SIZE      = ROW_BYTES * HEIGHT;
    localparam int FILE_SIZE     = HDR_BYTES + IMG_SIZE;
    localparam int BEATS_PER_ROW = WIDTH / PIX_PER_BEAT;
    localparam int BEAT_BYTES    = 3 * PIX_PER_BEAT;
    localparam int CW            = $clog2(BEATS_PER_ROW + 1);
    localparam int RW            = $clog2(HEIGHT + 1);
    localparam logic [31:0] HEIGHT_FIELD = (TOP_DOWN != 0) ? -(32'(HEIGHT)) : 32'(HEIGHT);

    if (WIDTH % PIX_PER_BEAT != 0) begin : g_width_check
        $error("bmp_stream_writer: WIDTH must be a multiple of PIX_PER_BEAT");
    end

    // Past the 2-byte signature every header field sits in a 4-byte slot
    // starting at offset 2; biPlanes and biBitCount share slot 6.
    function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
        logic [5:0]  rel;
        logic [31:0] word;
        rel = idx - 6'd2;
        case (rel[5:2])
            4'd0:    word = 32'(FILE_SIZE);
            4'd2:    word = 32'(HDR_BYTES);
            4'd3:    word = 32'd40;
            4'd4:    word = 32'(WIDTH);
            4'd5:    word = HEIGHT_FIELD;
            4'd6:    word = {16'd24, 16'd1};
            4'd8:    word = 32'(IMG_SIZE);
            default: word = 32'd0;
        endcase
        if (idx == 6'd0) return 8'h42;
        if (idx == 6'd1) return 8'h4D;
        return word[{rel[1:0], 3'b000} +: 8];
    endfunction

    typedef enum logic [2:0] {IDLE, HDR, LOAD, PIX, PAD, DONE} state_t;

    state_t                    state;
    logic [5:0]                hdr_idx;
    logic [3:0]                byte_idx;
    logic [CW-1:0]             col_cnt;
    logic [RW-1:0]             row_cnt;
    logic [1:0]                pad_cnt;
    logic [24*PIX_PER_BEAT-1:0] beat;
    logic xfer, beat_last, col_last, row_last, pad_last, row_end;

    assign xfer      = out_valid && out_ready;
    assign beat_last = byte_idx == 4'(BEAT_BYTES - 1);
    assign col_last  = col_cnt == CW'(BEATS_PER_ROW - 1);
    assign row_last  = row_cnt == RW'(HEIGHT - 1);
    assign pad_last  = pad_cnt == 2'(PAD_BYTES - 1);
    assign row_end   = xfer && ((state == PIX && beat_last && col_last && PAD_BYTES == 0) ||
                                (state == PAD && pad_last));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state      <= IDLE;
            hdr_idx    <= '0;
            byte_idx   <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            pad_cnt    <= '0;
            beat       <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            busy       <= 1'b0;
            Write_Done <= 1'b0;
        end else if (row_end) begin
            col_cnt   <= '0;
            pad_cnt   <= '0;
            byte_idx  <= '0;
            out_valid <= 1'b0;
            if (row_last) begin
                state      <= DONE;
                row_cnt    <= '0;
                busy       <= 1'b0;
                Write_Done <= 1'b1;
            end else begin
                state      <= LOAD;
                row_cnt    <= row_cnt + 1'b1;
                in_ready   <= 1'b1;
                Write_Done <= 1'b0;
            end
        end else begin
            Write_Done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= HDR;
                    busy      <= 1'b1;
                    hdr_idx   <= '0;
                    out_valid <= 1'b1;
                    out_data  <= hdr_byte(6'd0);
                end
                HDR: if (xfer) begin
                    if (hdr_idx == 6'(HDR_BYTES - 1)) begin
                        state     <= LOAD;
                        hdr_idx   <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        hdr_idx  <= hdr_idx + 6'd1;
                        out_data <= hdr_byte(hdr_idx + 6'd1);
                    end
                end
                // The beat is kept pre-shifted so its low byte is always the next one out.
                LOAD: if (in_valid) begin
                    state     <= PIX;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b1;
                    out_data  <= in_data[7:0];
                    beat      <= in_data >> 8;
                    byte_idx  <= '0;
                end
                PIX: if (xfer) begin
                    if (!beat_last) begin
                        byte_idx <= byte_idx + 4'd1;
                        out_data <= beat[7:0];
                        beat     <= beat >> 8;
                    end else if (!col_last) begin
                        byte_idx  <= '0;
                        col_cnt   <= col_cnt + 1'b1;
                        state     <= LOAD;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else begin
                        byte_idx <= '0;
                        col_cnt  <= '0;
                        state    <= PAD;
                        out_data <= 8'h00;
                    end
                end
                PAD: if (xfer) pad_cnt <= pad_cnt + 2'd1;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bmp_stream_writer.sv
// tb_bmp_stream_writer: directed frames on three writer configurations, checked
// byte-for-byte against a BMP model built inside the bench.
module tb_bmp_stream_writer;
    logic        HCLK = 1'b0;
    logic        HRESETn, start, in_valid, out_ready;
    logic [47:0] in_data;
    logic [1:0]  sel;

    logic       a_in_ready, a_out_valid, a_busy, a_done;
    logic       b_in_ready, b_out_valid, b_busy, b_done;
    logic       c_in_ready, c_out_valid, c_busy, c_done;
    logic [7:0] a_out_data, b_out_data, c_out_data;
    logic       m_in_ready, m_out_valid, m_busy, m_done;
    logic [7:0] m_out_data;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] golden_a[$];
    int done_cnt, done_lag, extra_done;
    bit aborted;

    always #5 HCLK = ~HCLK;

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .TOP_DOWN(0)) dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start && sel == 2'd0), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .busy(a_busy), .Write_Done(a_done));

    bmp_stream_writer #(.WIDTH(5), .HEIGHT(3), .PIX_PER_BEAT(1), .TOP_DOWN(0)) dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start && sel == 2'd1), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data[23:0]), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .busy(b_busy), .Write_Done(b_done));

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .PIX_PER_BEAT(2), .TOP_DOWN(1)) dut_c (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start && sel == 2'd2), .in_valid(in_valid),
        .in_ready(c_in_ready), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .busy(c_busy), .Write_Done(c_done));

    always_comb begin
        m_in_ready  = a_in_ready;
        m_out_valid = a_out_valid;
        m_out_data  = a_out_data;
        m_busy      = a_busy;
        m_done      = a_done;
        if (sel == 2'd1) begin
            m_in_ready  = b_in_ready;
            m_out_valid = b_out_valid;
            m_out_data  = b_out_data;
            m_busy      = b_busy;
            m_done      = b_done;
        end else if (sel == 2'd2) begin
            m_in_ready  = c_in_ready;
            m_out_valid = c_out_valid;
            m_out_data  = c_out_data;
            m_busy      = c_busy;
            m_done      = c_done;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_le(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*i +: 8]);
    endtask

    // Pixel n of the frame (supply order) is {R=n, G=0x80, B=0xFF}.
    task automatic build_expected(input int w, input int h, input bit td);
        int row_bytes, img;
        logic [7:0] n8;
        exp_q.delete();
        row_bytes = ((3 * w + 3) / 4) * 4;
        img = row_bytes * h;
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h4D);
        push_le(32'(54 + img), 4);
        push_le(32'd0, 4);
        push_le(32'd54, 4);
        push_le(32'd40, 4);
        push_le(32'(w), 4);
        push_le(td ? 32'(-h) : 32'(h), 4);
        push_le(32'd1, 2);
        push_le(32'd24, 2);
        push_le(32'd0, 4);
        push_le(32'(img), 4);
        for (int i = 0; i < 4; i++) push_le(32'd0, 4);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                n8 = 8'(r * w + c);
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'h80);
                exp_q.push_back(n8);
            end
            for (int p = 3 * w; p < row_bytes; p++) exp_q.push_back(8'h00);
        end
    endtask

    task automatic compare_stream(input string name);
        int n;
        checkOutput({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
    endtask

    // Runs one frame on the selected instance, collecting every transferred byte.
    task automatic applyStimulus(input bit rand_stall, input bit poke_start, input int abort_at);
        int ppb, pix, last_cyc, post;
        bit stalled, finished;
        logic [7:0] held;
        logic [31:0] n;
        got.delete();
        done_cnt = 0;
        done_lag = -1;
        aborted  = 1'b0;
        finished = 1'b0;
        stalled  = 1'b0;
        held     = 8'h00;
        pix = 0;
        last_cyc = -1000;
        post = 0;
        ppb = (sel == 2'd1) ? 1 : 2;
        start = 1'b1;
        @(posedge HCLK); #1;
        start = 1'b0;
        checkOutput($sformatf("busy_rise_sel%0d", sel), m_busy, 1);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (stalled) begin
                checkOutput($sformatf("hold_valid_c%0d", cyc), m_out_valid, 1);
                checkOutput($sformatf("hold_data_c%0d", cyc), m_out_data, held);
            end
            if (m_done) begin
                done_cnt++;
                done_lag = cyc - last_cyc;
            end
            if (done_cnt > 0) post++;
            if (post > 3) begin
                finished = 1'b1;
                break;
            end
            if (abort_at >= 0 && got.size() == abort_at) begin
                HRESETn   = 1'b0;
                start     = 1'b1;
                out_ready = 1'b1;
                @(posedge HCLK); #1;
                HRESETn = 1'b1;
                start   = 1'b0;
                checkOutput("abort_busy", m_busy, 0);
                checkOutput("abort_out_valid", m_out_valid, 0);
                checkOutput("abort_in_ready", m_in_ready, 0);
                aborted = 1'b1;
                break;
            end
            start     = poke_start && (got.size() == 10 || got.size() == 57);
            out_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = '0;
            for (int k = 0; k < ppb; k++) begin
                n = 32'(pix + k);
                in_data[24*k +: 24] = {n[7:0], 8'h80, 8'hFF};
            end
            if (m_in_ready && in_valid) pix += ppb;
            stalled = m_out_valid && !out_ready;
            held    = m_out_data;
            if (m_out_valid && out_ready) begin
                got.push_back(m_out_data);
                last_cyc = cyc;
            end
            @(posedge HCLK); #1;
        end
        start = 1'b0;
        checkOutput($sformatf("frame_timeout_sel%0d", sel), 32'(!(finished || aborted)), 0);
    endtask

    initial begin
        HRESETn   = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        sel       = 2'd0;
        repeat (3) @(posedge HCLK);
        #1;
        checkOutput("rst_in_ready", m_in_ready, 0);
        checkOutput("rst_out_valid", m_out_valid, 0);
        checkOutput("rst_out_data", m_out_data, 0);
        checkOutput("rst_busy", m_busy, 0);
        checkOutput("rst_write_done", m_done, 0);
        HRESETn  = 1'b1;
        in_valid = 1'b1;
        @(posedge HCLK); #1;
        checkOutput("idle_in_ready", m_in_ready, 0);
        checkOutput("idle_busy", m_busy, 0);

        $display("[TB] 4x2 frame, two pixels per beat, start pokes in HDR and PIX");
        sel = 2'd0;
        applyStimulus(1'b0, 1'b1, -1);
        build_expected(4, 2, 1'b0);
        compare_stream("a");
        checkOutput("a_done_cnt", done_cnt, 1);
        checkOutput("a_done_lag", done_lag, 1);
        checkOutput("a_busy_after", m_busy, 0);
        if (got.size() >= 78) begin
            checkOutput("a_sig", {got[1], got[0]}, 32'h4D42);
            checkOutput("a_file_size", {got[5], got[4], got[3], got[2]}, 32'h0000004E);
            checkOutput("a_height", {got[25], got[24], got[23], got[22]}, 32'h00000002);
            checkOutput("a_img_size", {got[37], got[36], got[35], got[34]}, 32'h00000018);
            checkOutput("a_first_pix", {got[54], got[55], got[56]}, 32'hFF8000);
            checkOutput("a_last_pix", {got[75], got[76], got[77]}, 32'hFF8007);
        end
        golden_a = got;

        $display("[TB] 5x3 frame, one pixel per beat, one pad byte per row");
        sel = 2'd1;
        applyStimulus(1'b0, 1'b0, -1);
        build_expected(5, 3, 1'b0);
        compare_stream("b");
        checkOutput("b_done_cnt", done_cnt, 1);
        if (got.size() >= 102) begin
            checkOutput("b_file_size", {got[5], got[4], got[3], got[2]}, 32'd102);
            checkOutput("b_first_pix", {got[54], got[55], got[56]}, 32'hFF8000);
            checkOutput("b_pad_row0", got[69], 32'h00);
            checkOutput("b_row1_first", {got[70], got[71], got[72]}, 32'hFF8005);
            checkOutput("b_pad_row2", got[101], 32'h00);
        end

        $display("[TB] 4x2 top-down frame");
        sel = 2'd2;
        applyStimulus(1'b0, 1'b0, -1);
        build_expected(4, 2, 1'b1);
        compare_stream("c");
        checkOutput("c_done_cnt", done_cnt, 1);
        if (got.size() >= 78 && golden_a.size() >= 78) begin
            checkOutput("c_height", {got[25], got[24], got[23], got[22]}, 32'hFFFFFFFE);
            for (int i = 0; i < 78; i++)
                if (i < 22 || i > 25)
                    checkOutput($sformatf("c_vs_a_byte%0d", i), got[i], golden_a[i]);
        end

        $display("[TB] 5x3 frame with random output stalls and input gaps");
        sel = 2'd1;
        applyStimulus(1'b1, 1'b0, -1);
        build_expected(5, 3, 1'b0);
        compare_stream("b_stall");
        checkOutput("b_stall_done_cnt", done_cnt, 1);

        $display("[TB] reset with coincident start in row 1, then a clean frame");
        sel = 2'd0;
        applyStimulus(1'b0, 1'b0, 70);
        checkOutput("abort_taken", 32'(aborted), 1);
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_done) extra_done++;
            @(posedge HCLK); #1;
        end
        checkOutput("abort_no_done", extra_done + done_cnt, 0);
        checkOutput("abort_idle_busy", m_busy, 0);
        applyStimulus(1'b0, 1'b0, -1);
        build_expected(4, 2, 1'b0);
        compare_stream("a_after_abort");
        checkOutput("a_after_abort_done_cnt", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
